// File: rtl/rob_pkg.sv
// Shared types and helpers for the circular reorder buffer.
// Entry payload widths are fixed here; rob_circ defaults its DATA_W/REG_W to them.
package rob_pkg;

    localparam int unsigned ROB_DATA_W = 32;
    localparam int unsigned ROB_REG_W  = 5;

    typedef struct packed {
        logic                  valid;
        logic                  ready;
        logic [ROB_DATA_W-1:0] instr;
        logic [ROB_REG_W-1:0]  rd;
        logic [ROB_DATA_W-1:0] val;
    } rob_entry_t;

    function automatic int unsigned tag_width(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    // Distance of idx from head in circular order; depth is a power of two.
    function automatic int unsigned age_off(input int unsigned idx, input int unsigned head,
                                            input int unsigned depth);
        return (idx - head) & (depth - 1);
    endfunction

endpackage

// File: rtl/rob_youngest_match.sv
// Picks the youngest (highest-age) set bit of a per-entry match vector.
// The vector is rotated so bit position equals age, then priority encoded.
module rob_youngest_match #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic [DEPTH-1:0] i_match,
    input  logic [TAG_W-1:0] i_head,
    output logic             o_found,
    output logic [TAG_W-1:0] o_idx
);

    logic [DEPTH-1:0] w_rot;
    logic [TAG_W-1:0] w_age;

    always_comb begin
        w_rot = '0;
        for (int unsigned a = 0; a < DEPTH; a++) begin
            w_rot[a] = i_match[i_head + TAG_W'(a)];
        end
    end

    always_comb begin
        w_age = '0;
        for (int unsigned a = 0; a < DEPTH; a++) begin
            if (w_rot[a]) w_age = TAG_W'(a);
        end
    end

    assign o_found = |w_rot;
    assign o_idx   = i_head + w_age;

endmodule

// File: rtl/rob_circ.sv
// Tag-indexed circular reorder buffer: in-order alloc/commit, out-of-order
// writeback by tag, flush of younger entries, and youngest-producer lookups.
module rob_circ
    import rob_pkg::*;
#(
    parameter  int unsigned DEPTH   = 32,
    parameter  int unsigned DATA_W  = ROB_DATA_W,
    parameter  int unsigned REG_W   = ROB_REG_W,
    parameter  int unsigned NUM_WB  = 2,
    parameter  int unsigned NUM_SRC = 4,
    localparam int unsigned TAG_W   = tag_width(DEPTH)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      push,
    input  logic [DATA_W-1:0]         push_instr,
    input  logic [REG_W-1:0]          push_rd,
    output logic [TAG_W-1:0]          alloc_tag,
    output logic                      full,
    output logic                      empty,
    output logic [TAG_W:0]            count,
    input  logic [NUM_WB-1:0]         wb_valid,
    input  logic [NUM_WB*TAG_W-1:0]   wb_tag,
    input  logic [NUM_WB*DATA_W-1:0]  wb_val,
    input  logic                      flush,
    input  logic [TAG_W-1:0]          flush_tag,
    input  logic [NUM_SRC*REG_W-1:0]  src_rd,
    output logic [NUM_SRC-1:0]        src_hit,
    output logic [NUM_SRC-1:0]        src_ready,
    output logic [NUM_SRC*TAG_W-1:0]  src_tag,
    output logic [NUM_SRC*DATA_W-1:0] src_val,
    output logic                      head_valid,
    output logic                      head_ready,
    output logic [DATA_W-1:0]         head_instr,
    output logic [REG_W-1:0]          head_rd,
    output logic [DATA_W-1:0]         head_val,
    output logic [TAG_W-1:0]          head_tag,
    input  logic                      pop
);

    localparam int unsigned PTR_W = TAG_W + 1;

    logic [PTR_W-1:0] r_head, r_tail;
    rob_entry_t       r_ent     [DEPTH];
    rob_entry_t       w_ent_nxt [DEPTH];
    logic [PTR_W-1:0] w_head_nxt, w_tail_nxt, w_count;
    logic [TAG_W-1:0] w_head_idx, w_tail_idx;
    rob_entry_t       w_head_ent;
    logic             w_push_acc, w_pop_acc, w_flush_acc;
    int unsigned      w_flush_age;

    assign w_head_idx = r_head[TAG_W-1:0];
    assign w_tail_idx = r_tail[TAG_W-1:0];
    assign w_head_ent = r_ent[w_head_idx];
    assign w_count    = r_tail - r_head;

    assign count     = w_count;
    assign full      = (w_count == PTR_W'(DEPTH));
    assign empty     = (w_count == '0);
    assign alloc_tag = w_tail_idx;

    // Invalid entries hold zero data, so gating only the valid-derived bits matters.
    assign head_valid = w_head_ent.valid;
    assign head_ready = w_head_ent.valid & w_head_ent.ready;
    assign head_instr = w_head_ent.valid ? w_head_ent.instr : '0;
    assign head_rd    = w_head_ent.valid ? w_head_ent.rd    : '0;
    assign head_val   = w_head_ent.valid ? w_head_ent.val   : '0;
    assign head_tag   = w_head_ent.valid ? w_head_idx       : '0;

    assign w_push_acc  = push & ~full & ~flush;
    assign w_pop_acc   = pop & head_valid & head_ready;
    assign w_flush_acc = flush & r_ent[flush_tag].valid;
    assign w_flush_age = age_off(32'(flush_tag), 32'(w_head_idx), DEPTH);

    always_comb begin
        w_head_nxt = r_head;
        w_tail_nxt = r_tail;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_ent_nxt[i] = r_ent[i];
        end

        // Ports scanned high to low so the lowest index is applied last and wins.
        for (int unsigned i = 0; i < DEPTH; i++) begin
            for (int k = int'(NUM_WB) - 1; k >= 0; k--) begin
                if (wb_valid[k] && (wb_tag[k*TAG_W +: TAG_W] == TAG_W'(i)) && r_ent[i].valid) begin
                    w_ent_nxt[i].ready = 1'b1;
                    w_ent_nxt[i].val   = wb_val[k*DATA_W +: DATA_W];
                end
            end
        end

        if (w_pop_acc) begin
            w_ent_nxt[w_head_idx] = '0;
            w_head_nxt            = r_head + PTR_W'(1);
        end

        if (w_flush_acc) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (age_off(i, 32'(w_head_idx), DEPTH) > w_flush_age) w_ent_nxt[i] = '0;
            end
            w_tail_nxt = r_head + PTR_W'(w_flush_age) + PTR_W'(1);
        end else if (w_push_acc) begin
            w_ent_nxt[w_tail_idx].valid = 1'b1;
            w_ent_nxt[w_tail_idx].ready = 1'b0;
            w_ent_nxt[w_tail_idx].instr = push_instr;
            w_ent_nxt[w_tail_idx].rd    = push_rd;
            w_ent_nxt[w_tail_idx].val   = '0;
            w_tail_nxt                  = r_tail + PTR_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_head <= '0;
            r_tail <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) r_ent[i] <= '0;
        end else begin
            r_head <= w_head_nxt;
            r_tail <= w_tail_nxt;
            for (int unsigned i = 0; i < DEPTH; i++) r_ent[i] <= w_ent_nxt[i];
        end
    end

    // One youngest-producer search per lookup port.
    for (genvar j = 0; j < NUM_SRC; j++) begin : g_src
        logic [REG_W-1:0] w_rd;
        logic [DEPTH-1:0] w_match;
        logic             w_found;
        logic             w_rdy;
        logic [TAG_W-1:0] w_idx;

        assign w_rd = src_rd[j*REG_W +: REG_W];

        always_comb begin
            w_match = '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                w_match[i] = r_ent[i].valid && (r_ent[i].rd == w_rd) && (w_rd != '0);
            end
        end

        rob_youngest_match #(
            .DEPTH (DEPTH),
            .TAG_W (TAG_W)
        ) u_match (
            .i_match (w_match),
            .i_head  (w_head_idx),
            .o_found (w_found),
            .o_idx   (w_idx)
        );

        assign w_rdy                          = w_found & r_ent[w_idx].ready;
        assign src_hit[j]                     = w_found;
        assign src_ready[j]                   = w_rdy;
        assign src_tag[j*TAG_W +: TAG_W]      = w_found ? w_idx : '0;
        assign src_val[j*DATA_W +: DATA_W]    = w_rdy ? r_ent[w_idx].val : '0;
    end

endmodule
